// File: rtl/axi4_upsz_pkg.sv
// Shared types and helpers for the 64b -> 512b AXI4 upsizer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// The offset/lane widths below are derived from the default narrow and
// wide data widths; the top-level NARROW_W/WIDE_W parameters must match
// these defaults.
package axi4_upsz_pkg;

  localparam int DFLT_NARROW_W = 64;
  localparam int DFLT_WIDE_W   = 512;

  // Byte offset within one wide word, and the low bits that address a byte
  // inside a single narrow lane.
  localparam int OFF_BITS  = $clog2(DFLT_WIDE_W / 8);
  localparam int NB_BITS   = $clog2(DFLT_NARROW_W / 8);
  localparam int LANE_BITS = OFF_BITS - NB_BITS;

  typedef struct packed {
    logic [OFF_BITS-1:0] off;
    logic [2:0]          size;
  } trk_entry_t;

  // Next beat address of an INCR burst, reduced modulo the wide word:
  // align down to the transfer size, then step by one transfer.
  function automatic logic [OFF_BITS-1:0] step_off(input logic [OFF_BITS-1:0] off,
                                                   input logic [2:0]          size);
    logic [OFF_BITS-1:0] inc;
    inc = OFF_BITS'(1) << size;
    return (off & ~(inc - OFF_BITS'(1))) + inc;
  endfunction

endpackage

// File: rtl/axi4_upsz_trk_fifo.sv
// Burst tracking FIFO holding {wide-word offset, size} per accepted burst.
// Latency: entry visible at head the cycle after the push edge; no bypass.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
//
// Ports: clk/rst_n clock and async active-low reset; push_vld/push_dat write
// side with full flag; pop_vld/head_dat read side with empty flag.
module axi4_upsz_trk_fifo
  import axi4_upsz_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_vld,
  input  trk_entry_t push_dat,
  output logic       full,
  input  logic       pop_vld,
  output trk_entry_t head_dat,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  trk_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push_vld & ~full;
  assign do_pop   = pop_vld & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi4_ddr_upsizer.sv
// AXI4 64b -> 512b upsizer with address-correct byte-lane steering; one narrow beat = one wide beat.
// Latency: zero added latency on every channel (combinational steering, tracking FIFOs off the data path).
// Backpressure: AW/AR stall when their tracking FIFO is full; W stalls until its AW is tracked; AR also stalls on an ID change while reads are in flight.
//
// Ports: aclk/aresetn clock and async active-low reset.
//   s_axi_aw*/w*/b*/ar*/r*  narrow slave port (from the shim master), data NARROW_W.
//   m_axi_aw*/w*/b*/ar*/r*  wide master port (to the DDR slave), data WIDE_W.
module axi4_ddr_upsizer
  import axi4_upsz_pkg::*;
#(
  parameter int NARROW_W    = DFLT_NARROW_W,
  parameter int WIDE_W      = DFLT_WIDE_W,
  parameter int ADDR_W      = 64,
  parameter int ID_W        = 16,
  parameter int OUTSTANDING = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // narrow write address
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [ID_W-1:0]       s_axi_awid,
  // narrow write data
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [NARROW_W-1:0]   s_axi_wdata,
  input  logic [NARROW_W/8-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  // narrow write response
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  output logic [ID_W-1:0]       s_axi_bid,
  // narrow read address
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [ID_W-1:0]       s_axi_arid,
  // narrow read data
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [NARROW_W-1:0]   s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic [ID_W-1:0]       s_axi_rid,
  // wide write address
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [ID_W-1:0]       m_axi_awid,
  // wide write data
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [WIDE_W-1:0]     m_axi_wdata,
  output logic [WIDE_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  // wide write response
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  input  logic [ID_W-1:0]       m_axi_bid,
  // wide read address
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [ID_W-1:0]       m_axi_arid,
  // wide read data
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [WIDE_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic [ID_W-1:0]       m_axi_rid
);

  localparam int NB    = NARROW_W / 8;
  localparam int WB    = WIDE_W / 8;
  localparam int RATIO = WIDE_W / NARROW_W;

  // Holds every handshake output low while in reset and for the first
  // cycle after release, so nothing is accepted before the FIFOs settle.
  logic run;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) run <= 1'b0;
    else          run <= 1'b1;
  end

  // ---------------- write path ----------------
  trk_entry_t          w_push_dat;
  trk_entry_t          w_head;
  logic                w_full, w_empty;
  logic                aw_ok, w_ok;
  logic                aw_hs, w_hs, w_pop;
  logic                w_mid;
  logic [OFF_BITS-1:0] w_off, w_cur_off;
  logic [LANE_BITS-1:0] w_lane;

  assign aw_ok         = run & ~w_full;
  assign m_axi_awvalid = s_axi_awvalid & aw_ok;
  assign s_axi_awready = m_axi_awready & aw_ok;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awid    = s_axi_awid;
  assign aw_hs         = s_axi_awvalid & s_axi_awready;

  assign w_push_dat.off  = s_axi_awaddr[OFF_BITS-1:0];
  assign w_push_dat.size = s_axi_awsize;

  axi4_upsz_trk_fifo #(.DEPTH(OUTSTANDING)) u_wtrk (
    .clk      (aclk),
    .rst_n    (aresetn),
    .push_vld (aw_hs),
    .push_dat (w_push_dat),
    .full     (w_full),
    .pop_vld  (w_pop),
    .head_dat (w_head),
    .empty    (w_empty)
  );

  // Gating on a non-empty tracker keeps W from overtaking its AW.
  assign w_ok         = run & ~w_empty;
  assign m_axi_wvalid = s_axi_wvalid & w_ok;
  assign s_axi_wready = m_axi_wready & w_ok;
  assign w_hs         = s_axi_wvalid & s_axi_wready;
  assign w_pop        = w_hs & s_axi_wlast;

  // First beat of a burst takes the offset straight from the tracker head;
  // later beats use the stepped offset register.
  assign w_cur_off    = w_mid ? w_off : w_head.off;
  assign w_lane       = w_cur_off[OFF_BITS-1:NB_BITS];
  assign m_axi_wdata  = {RATIO{s_axi_wdata}};
  assign m_axi_wstrb  = WB'(s_axi_wstrb) << (w_lane * NB);
  assign m_axi_wlast  = s_axi_wlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_mid <= 1'b0;
      w_off <= '0;
    end else if (w_hs) begin
      if (s_axi_wlast) begin
        w_mid <= 1'b0;
      end else begin
        w_mid <= 1'b1;
        w_off <= step_off(w_cur_off, w_head.size);
      end
    end
  end

  assign s_axi_bvalid = m_axi_bvalid & run;
  assign m_axi_bready = s_axi_bready & run;
  assign s_axi_bresp  = m_axi_bresp;
  assign s_axi_bid    = m_axi_bid;

  // ---------------- read path ----------------
  trk_entry_t          r_push_dat;
  trk_entry_t          r_head;
  logic                r_full, r_empty;
  logic                ar_ok, ar_hs, r_hs, r_pop;
  logic [ID_W-1:0]     last_arid;
  logic                r_mid;
  logic [OFF_BITS-1:0] r_off, r_cur_off;
  logic [LANE_BITS-1:0] r_lane;

  // Only one ID may be in flight at a time, so R beats return in AR order
  // and the tracker head always describes the beat on the bus.
  assign ar_ok         = run & ~r_full & (r_empty | (s_axi_arid == last_arid));
  assign m_axi_arvalid = s_axi_arvalid & ar_ok;
  assign s_axi_arready = m_axi_arready & ar_ok;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arid    = s_axi_arid;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;

  assign r_push_dat.off  = s_axi_araddr[OFF_BITS-1:0];
  assign r_push_dat.size = s_axi_arsize;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)   last_arid <= '0;
    else if (ar_hs) last_arid <= s_axi_arid;
  end

  axi4_upsz_trk_fifo #(.DEPTH(OUTSTANDING)) u_rtrk (
    .clk      (aclk),
    .rst_n    (aresetn),
    .push_vld (ar_hs),
    .push_dat (r_push_dat),
    .full     (r_full),
    .pop_vld  (r_pop),
    .head_dat (r_head),
    .empty    (r_empty)
  );

  assign s_axi_rvalid = m_axi_rvalid & run;
  assign m_axi_rready = s_axi_rready & run;
  assign r_hs         = m_axi_rvalid & m_axi_rready;
  assign r_pop        = r_hs & m_axi_rlast;

  assign r_cur_off    = r_mid ? r_off : r_head.off;
  assign r_lane       = r_cur_off[OFF_BITS-1:NB_BITS];
  assign s_axi_rdata  = m_axi_rdata[r_lane*NARROW_W +: NARROW_W];
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast;
  assign s_axi_rid    = m_axi_rid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_mid <= 1'b0;
      r_off <= '0;
    end else if (r_hs) begin
      if (m_axi_rlast) begin
        r_mid <= 1'b0;
      end else begin
        r_mid <= 1'b1;
        r_off <= step_off(r_cur_off, r_head.size);
      end
    end
  end

endmodule

// File: tb/tb_axi4_ddr_upsizer.sv
// Scoreboard bench for axi4_ddr_upsizer: directed AW/W/B/AR/R traffic with
// hand-computed lanes; monitors pop expected beats on every output handshake.
module tb_axi4_ddr_upsizer;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic         s_axi_awvalid, s_axi_awready;
  logic [63:0]  s_axi_awaddr;
  logic [7:0]   s_axi_awlen;
  logic [2:0]   s_axi_awsize;
  logic [15:0]  s_axi_awid;
  logic         s_axi_wvalid, s_axi_wready;
  logic [63:0]  s_axi_wdata;
  logic [7:0]   s_axi_wstrb;
  logic         s_axi_wlast;
  logic         s_axi_bvalid, s_axi_bready;
  logic [1:0]   s_axi_bresp;
  logic [15:0]  s_axi_bid;
  logic         s_axi_arvalid, s_axi_arready;
  logic [63:0]  s_axi_araddr;
  logic [7:0]   s_axi_arlen;
  logic [2:0]   s_axi_arsize;
  logic [15:0]  s_axi_arid;
  logic         s_axi_rvalid, s_axi_rready;
  logic [63:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic [15:0]  s_axi_rid;
  logic         m_axi_awvalid, m_axi_awready;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [15:0]  m_axi_awid;
  logic         m_axi_wvalid, m_axi_wready;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_bvalid, m_axi_bready;
  logic [1:0]   m_axi_bresp;
  logic [15:0]  m_axi_bid;
  logic         m_axi_arvalid, m_axi_arready;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [15:0]  m_axi_arid;
  logic         m_axi_rvalid, m_axi_rready;
  logic [511:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast;
  logic [15:0]  m_axi_rid;

  axi4_ddr_upsizer dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awid(s_axi_awid),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arid(s_axi_arid),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awid(m_axi_awid),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arid(m_axi_arid),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [511:0] d; logic [63:0] s; logic last; } wexp_t;
  typedef struct { logic [63:0] d; logic last; logic [15:0] id; } rexp_t;
  typedef struct { logic [1:0] resp; logic [15:0] id; } bexp_t;
  typedef struct { logic [63:0] a; logic [7:0] l; logic [2:0] sz; logic [15:0] id; } aexp_t;

  wexp_t exp_w[$];
  rexp_t exp_r[$];
  bexp_t exp_b[$];
  aexp_t exp_aw[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for handshake", name);
  endtask

  // ---------------- scoreboard monitors ----------------
  wexp_t mw;
  rexp_t mr;
  bexp_t mb;
  aexp_t ma;

  always @(negedge aclk) begin
    if (m_axi_awvalid && m_axi_awready) begin
      if (exp_aw.size() == 0) timeout("aw_unexpected");
      else begin
        ma = exp_aw.pop_front();
        check("m_awaddr", 512'(m_axi_awaddr), 512'(ma.a));
        check("m_awlen_size_id", 512'({m_axi_awlen, m_axi_awsize, m_axi_awid}), 512'({ma.l, ma.sz, ma.id}));
      end
    end
    if (m_axi_wvalid && m_axi_wready) begin
      if (exp_w.size() == 0) timeout("w_unexpected");
      else begin
        mw = exp_w.pop_front();
        check("m_wdata", m_axi_wdata, mw.d);
        check("m_wstrb", 512'(m_axi_wstrb), 512'(mw.s));
        check("m_wlast", 512'(m_axi_wlast), 512'(mw.last));
      end
    end
    if (s_axi_bvalid && s_axi_bready) begin
      if (exp_b.size() == 0) timeout("b_unexpected");
      else begin
        mb = exp_b.pop_front();
        check("s_bresp_id", 512'({s_axi_bresp, s_axi_bid}), 512'({mb.resp, mb.id}));
      end
    end
    if (s_axi_rvalid && s_axi_rready) begin
      if (exp_r.size() == 0) timeout("r_unexpected");
      else begin
        mr = exp_r.pop_front();
        check("s_rdata", 512'(s_axi_rdata), 512'(mr.d));
        check("s_rlast_id", 512'({s_axi_rlast, s_axi_rid}), 512'({mr.last, mr.id}));
      end
    end
  end

  // Protocol guards on the stimulus itself.
  always @(posedge aclk) begin
    if (aresetn && s_axi_awvalid) assert (s_axi_awsize <= 3'd3) else $error("illegal awsize %0d", s_axi_awsize);
    if (aresetn && s_axi_arvalid) assert (s_axi_arsize <= 3'd3) else $error("illegal arsize %0d", s_axi_arsize);
    if (aresetn && m_axi_rvalid)  assert (!dut.u_rtrk.empty) else $error("R beat with no tracked read");
  end

  // ---------------- drivers (entered at posedge+1) ----------------
  task automatic aw(input logic [63:0] a, input logic [7:0] l, input logic [2:0] sz, input logic [15:0] id);
    int n;
    exp_aw.push_back('{a, l, sz, id});
    s_axi_awaddr = a; s_axi_awlen = l; s_axi_awsize = sz; s_axi_awid = id; s_axi_awvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_axi_awready && n < 100);
    if (!s_axi_awready) timeout("aw");
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic wbeat(input logic [63:0] d, input logic [7:0] strb, input logic last, input int lane);
    int n;
    exp_w.push_back('{{8{d}}, 64'(strb) << (lane * 8), last});
    s_axi_wdata = d; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_axi_wready && n < 100);
    if (!s_axi_wready) timeout("w");
    @(posedge aclk); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic bresp(input logic [15:0] id, input logic [1:0] resp);
    int n;
    exp_b.push_back('{resp, id});
    m_axi_bid = id; m_axi_bresp = resp; m_axi_bvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!m_axi_bready && n < 100);
    if (!m_axi_bready) timeout("b");
    @(posedge aclk); #1;
    m_axi_bvalid = 1'b0;
  endtask

  task automatic ar(input logic [63:0] a, input logic [7:0] l, input logic [2:0] sz, input logic [15:0] id);
    int n;
    s_axi_araddr = a; s_axi_arlen = l; s_axi_arsize = sz; s_axi_arid = id; s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_axi_arready && n < 100);
    if (!s_axi_arready) timeout("ar");
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  // Every wide lane i carries {tag, i}; the expected narrow beat is the
  // lane the address should select.
  task automatic rbeat(input logic [31:0] tag, input int lane, input logic last, input logic [15:0] id);
    int n;
    exp_r.push_back('{{tag, 32'(lane)}, last, id});
    for (int i = 0; i < 8; i++) m_axi_rdata[i*64 +: 64] = {tag, 32'(i)};
    m_axi_rlast = last; m_axi_rid = id; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!m_axi_rready && n < 100);
    if (!m_axi_rready) timeout("r");
    @(posedge aclk); #1;
    m_axi_rvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    aresetn = 1'b0;
    s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 3; s_axi_awid = 0;
    s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0;
    s_axi_bready = 1;
    s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 3; s_axi_arid = 0;
    s_axi_rready = 1;
    m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
    m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rid = 0;

    // reset state: readies held low even with downstream ready
    @(negedge aclk);
    check("rst_s_awready", 512'(s_axi_awready), 0);
    check("rst_s_arready", 512'(s_axi_arready), 0);
    check("rst_m_bready",  512'(m_axi_bready), 0);
    check("rst_m_rready",  512'(m_axi_rready), 0);
    check("rst_wtrk_empty", 512'(dut.u_wtrk.empty), 1);
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // single write at 0x48 -> lane 1
    aw(64'h48, 8'd0, 3'd3, 16'd1);
    wbeat(64'h1122_3344_5566_7788, 8'hFF, 1'b1, 1);
    bresp(16'd1, 2'b00);

    // burst 0x30 size 3 len 3 -> lanes 6,7,0,1
    aw(64'h1030, 8'd3, 3'd3, 16'd2);
    wbeat(64'hA0A0_0000_0000_0001, 8'hFF, 1'b0, 6);
    wbeat(64'hA0A0_0000_0000_0002, 8'hFF, 1'b0, 7);
    wbeat(64'hA0A0_0000_0000_0003, 8'hFF, 1'b0, 0);
    wbeat(64'hA0A0_0000_0000_0004, 8'hFF, 1'b1, 1);
    bresp(16'd2, 2'b00);
    @(negedge aclk);
    check("wtrk_empty_after_burst", 512'(dut.u_wtrk.empty), 1);
    @(posedge aclk); #1;

    // unaligned 0x33 size 2 -> offsets 0x33,0x34,0x38 -> lanes 6,6,7
    aw(64'h33, 8'd2, 3'd2, 16'd3);
    wbeat(64'hB0B0_0000_0000_0001, 8'h08, 1'b0, 6);
    wbeat(64'hB0B0_0000_0000_0002, 8'hF0, 1'b0, 6);
    wbeat(64'hB0B0_0000_0000_0003, 8'h0F, 1'b1, 7);
    bresp(16'd3, 2'b10);

    // read len 1 at 0x78 -> lanes 7 then 0
    ar(64'h78, 8'd1, 3'd3, 16'd7);
    rbeat(32'hAAAA_0001, 7, 1'b0, 16'd7);
    rbeat(32'hAAAA_0002, 0, 1'b1, 16'd7);
    @(negedge aclk);
    check("rtrk_empty_after_read", 512'(dut.u_rtrk.empty), 1);
    @(posedge aclk); #1;

    // 8 outstanding reads with ID 3 at 0x00..0x38 (lanes 0..7)
    for (int i = 0; i < 8; i++) ar(64'(i * 8), 8'd0, 3'd3, 16'd3);
    @(negedge aclk);
    check("rtrk_full_8", 512'(dut.u_rtrk.full), 1);
    @(posedge aclk); #1;
    s_axi_araddr = 64'h40; s_axi_arlen = 0; s_axi_arsize = 3; s_axi_arid = 16'd3; s_axi_arvalid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("ar9_stall_full", 512'({s_axi_arready, m_axi_arvalid}), 0);
    end
    @(posedge aclk); #1;
    rbeat(32'hC000_0000, 0, 1'b1, 16'd3);
    @(negedge aclk);
    check("ar9_accept_after_rlast", 512'(s_axi_arready), 1);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;

    // ID 5 must wait until every ID 3 read has drained
    s_axi_araddr = 64'h10; s_axi_arid = 16'd5; s_axi_arvalid = 1'b1;
    @(negedge aclk);
    check("ar_id5_stall", 512'({s_axi_arready, m_axi_arvalid}), 0);
    @(posedge aclk); #1;
    for (int i = 1; i < 8; i++) rbeat(32'hC000_0000 + 32'(i), i, 1'b1, 16'd3);
    @(negedge aclk);
    check("ar_id5_stall_last", 512'(s_axi_arready), 0);
    @(posedge aclk); #1;
    rbeat(32'hC000_0008, 0, 1'b1, 16'd3);
    @(negedge aclk);
    check("ar_id5_accept_empty", 512'(s_axi_arready), 1);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    rbeat(32'hD000_0005, 2, 1'b1, 16'd5);

    // W before AW, then same-cycle AW push and wlast pop
    exp_w.push_back('{{8{64'hE0E0_0000_0000_0001}}, 64'hFF << 16, 1'b1});
    s_axi_wdata = 64'hE0E0_0000_0000_0001; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    repeat (2) begin
      @(negedge aclk);
      check("w_before_aw_stall", 512'({s_axi_wready, m_axi_wvalid}), 0);
    end
    @(posedge aclk); #1;
    fork
      begin
        aw(64'h10, 8'd0, 3'd3, 16'd4);
        aw(64'h20, 8'd0, 3'd3, 16'd5);
      end
      begin
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_wready && n < 100);
        if (!s_axi_wready) timeout("w_early");
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
      end
    join
    @(negedge aclk);
    check("wtrk_count_push_pop", 512'(dut.u_wtrk.count), 1);
    @(posedge aclk); #1;
    wbeat(64'hE0E0_0000_0000_0002, 8'hFF, 1'b1, 4);
    bresp(16'd4, 2'b00);
    bresp(16'd5, 2'b01);

    // reset mid-burst
    aw(64'h0, 8'd3, 3'd3, 16'd6);
    wbeat(64'hF0F0_0000_0000_0001, 8'hFF, 1'b0, 0);
    wbeat(64'hF0F0_0000_0000_0002, 8'hFF, 1'b0, 1);
    s_axi_awaddr = 64'h8; s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0;
    s_axi_araddr = 64'h8; s_axi_arid = 16'd9; s_axi_arvalid = 1'b1;
    aresetn = 1'b0;
    @(negedge aclk);
    check("midrst_aw", 512'({s_axi_awready, m_axi_awvalid}), 0);
    check("midrst_w",  512'({s_axi_wready, m_axi_wvalid}), 0);
    check("midrst_ar", 512'({s_axi_arready, m_axi_arvalid}), 0);
    check("midrst_fifos_empty", 512'({dut.u_wtrk.empty, dut.u_rtrk.empty}), 512'(2'b11));
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    aw(64'h48, 8'd0, 3'd3, 16'd8);
    wbeat(64'h0123_4567_89AB_CDEF, 8'h3C, 1'b1, 1);
    bresp(16'd8, 2'b00);

    repeat (3) @(negedge aclk);
    check("drain_w",  512'(exp_w.size()), 0);
    check("drain_r",  512'(exp_r.size()), 0);
    check("drain_b",  512'(exp_b.size()), 0);
    check("drain_aw", 512'(exp_aw.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
